hv_stream_packer: RTL and testbench
===================================

# hv_stream_packer

Output stage placed directly downstream of the per-dimension counter/sign-bit buffer controller. Each cycle the controller pulses `stream_v`, the block captures one full hypervector into a 2-entry ping-pong buffer. It then serializes each vector into DW-bit AXI-Stream beats for the DMA write channel, and asserts `dst_last` on the final beat of a job of programmable length. Vectors that arrive while both buffer entries are occupied are dropped and flagged, because the upstream stage has no backpressure.

## Interface
- `DIM`, 1023: hypervector MSB index; vector width is DIM+1.
- `DW`, 64: output beat width. Legal only if DW is a power of two and (DIM+1) % DW == 0.
- `BEATS`, (DIM+1)/DW: derived value (16 at defaults). Not overridable.
- `clk`  in  1  single clock; every register is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a job. Honoured only in IDLE.
- `job_len`  in  16  number of vectors in the job. Sampled on an accepted `start`.
- `stream_v`  in  1  one-cycle pulse: `stream_d` holds a valid vector this cycle.
- `stream_d`  in  DIM+1  hypervector sign bits.
- `dst_data`  out  DW  output beat.
- `dst_valid`  out  1  AXI-Stream valid.
- `dst_ready`  in  1  AXI-Stream ready.
- `dst_last`  out  1  high on the last beat of the last vector of the job.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at job completion.
- `overflow`  out  1  sticky flag: a vector was dropped. Cleared by an accepted `start`.

## Operation
- States: IDLE and RUN.
  - IDLE→RUN on `start`, which latches `job_len`, clears the vector counter `vcnt` and clears `overflow`.
  - `start` is ignored while in RUN.
  - With `job_len`==0, the block goes IDLE→RUN→IDLE, pulses `done` one cycle after `start`, and emits no beats.
- Buffer: two entries of DIM+1 bits, a write pointer, a read pointer and an occupancy count `occ` in the range 0..2.
  - In RUN, `stream_v` with `occ`<2 writes the vector to the entry at the write pointer.
  - In RUN, `stream_v` with `occ`==2 drops the vector and sets `overflow`. Exception: if the final beat of the head entry handshakes in the same cycle, that entry is freed, so the write is accepted and `occ` stays at 2.
  - In IDLE, `stream_v` is ignored and does not set `overflow`.
- Serializer:
  - Beat counter `bcnt` runs 0..BEATS-1. Beat k is `dst_data` = head[k*DW +: DW], LSB-first.
  - A beat handshakes when `dst_valid`&&`dst_ready`, which advances `bcnt`.
  - On the beat with `bcnt`==BEATS-1 the handshake pops the head entry, wraps `bcnt` to 0 and increments `vcnt`.
- `dst_last` = `dst_valid` && `bcnt`==BEATS-1 && `vcnt`==`job_len`-1.
- Completion: when the `dst_last` beat handshakes, the next cycle has state IDLE, `done`=1 for one cycle, and `busy`=0. Vectors still buffered at that point are discarded: `occ` is set to 0.
- Width rules:
  - `vcnt` is 16 bits and never wraps within a job.
  - `bcnt` is $clog2(BEATS) bits.

## Timing
- Reset values: `dst_data`=0, `dst_valid`=0, `dst_last`=0, `busy`=0, `done`=0, `overflow`=0. Also `occ`=0, both pointers=0, `bcnt`=0, `vcnt`=0, state IDLE.
- Reset asserted mid-job aborts immediately. Nothing resumes after release; a new `start` is required.
- Latency: `stream_v` at cycle t with `occ`==0 gives `dst_valid`=1 with beat 0 at cycle t+1. All outputs are registered.
- Throughput: with `dst_ready` held high, one beat per cycle and BEATS cycles per vector. Consecutive vectors stream back-to-back with no bubble.
- AXI-Stream rule: while `dst_valid`&&!`dst_ready`, `dst_data` and `dst_last` hold stable. `dst_valid` never drops without a handshake.
- `busy` rises the cycle after an accepted `start`.
- `done` and `busy`=0 occur in the same cycle.

## Test plan
- Single vector, defaults: `start` with `job_len`=1, then `stream_v` with `stream_d`=1024'h…0F0E…0100 (beat k = 64'h0k-pattern), `dst_ready`=1. Required: 16 beats in cycles t+1..t+16 in LSB-first order, `dst_last` only on beat 15, `done` at t+17.
- Backpressure: `job_len`=2, two vectors, `dst_ready` toggling 1,0,0,1. Required: `dst_data` stable during stalls, 32 beats total, `dst_last` only on beat 31.
- Overflow: `job_len`=4, `dst_ready`=0, three `stream_v` pulses. Required: first two buffered, third dropped, `overflow`=1; next `start` clears it.
- Simultaneous free and write: `occ`=2, and `stream_v` arrives in the same cycle as the final-beat handshake. Required: vector accepted, `overflow` stays 0, `occ` stays 2.
- Zero-length job: `job_len`=0. Required: `done` one cycle after `start`, `dst_valid` never asserted.
- Reset mid-job: `rst`=0 at beat 7 of vector 1. Required: all outputs return to reset values asynchronously. After release, `stream_v` without `start` produces no beats.

Source files
------------

// File: rtl/hv_stream_packer_if.sv
// AXI-Stream beat channel from the hypervector packer to the DMA write path.
interface hv_stream_packer_if #(
   parameter int DW = 64
);
   logic [DW-1:0] dst_data;
   logic          dst_valid;
   logic          dst_ready;
   logic          dst_last;

   modport master (
      output dst_data,
      output dst_valid,
      output dst_last,
      input  dst_ready
   );

   modport slave (
      input  dst_data,
      input  dst_valid,
      input  dst_last,
      output dst_ready
   );
endinterface

// File: rtl/hv_stream_packer.sv
// Hypervector packer: captures whole vectors into a 2-entry ping-pong buffer
// and serializes them LSB-first into DW-bit stream beats for a job of
// job_len vectors. The upstream stage cannot stall, so vectors arriving with
// both entries full are dropped and flagged in the sticky overflow bit.
// DW must be a power of two and must divide DIM+1.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; stream_v ignored, no beats
//   RUN   | capturing vectors and emitting beats until the last beat
module hv_stream_packer #(
   parameter int DIM = 1023,
   parameter int DW  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       job_len,
   input  logic              stream_v,
   input  logic [DIM:0]      stream_d,
   hv_stream_packer_if.master dst,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int BEATS = (DIM + 1) / DW;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] BLAST = BW'(BEATS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_n;
   logic [DIM:0]  buf_q [2];
   logic [DIM:0]  buf_n [2];
   logic [DIM:0]  head_n;
   logic          wptr_q, wptr_n;
   logic          rptr_q, rptr_n;
   logic [1:0]    occ_q, occ_n;
   logic [BW-1:0] bcnt_q, bcnt_n;
   logic [15:0]   vcnt_q, vcnt_n;
   logic [15:0]   len_q, len_n;
   logic [DW-1:0] data_q, data_n;
   logic          valid_q, valid_n;
   logic          last_q, last_n;
   logic          busy_n, done_n, ovf_n;
   logic          hs, pop, wr, finish;

   assign dst.dst_data  = data_q;
   assign dst.dst_valid = valid_q;
   assign dst.dst_last  = last_q;

   // Next-state, buffer bookkeeping and the registered-output precompute.
   always_comb begin
      state_n = state_q;
      buf_n   = buf_q;
      wptr_n  = wptr_q;
      rptr_n  = rptr_q;
      occ_n   = occ_q;
      bcnt_n  = bcnt_q;
      vcnt_n  = vcnt_q;
      len_n   = len_q;
      ovf_n   = overflow;
      done_n  = 1'b0;
      hs      = valid_q && dst.dst_ready;
      pop     = hs && (bcnt_q == BLAST);
      finish  = hs && last_q;
      wr      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               len_n   = job_len;
               vcnt_n  = '0;
               ovf_n   = 1'b0;
               occ_n   = '0;
               wptr_n  = 1'b0;
               rptr_n  = 1'b0;
               bcnt_n  = '0;
            end
         end
         RUN: begin
            // A full buffer still accepts a vector if the head frees this cycle.
            wr = stream_v && ((occ_q != 2'd2) || pop);
            if (stream_v && !wr)
               ovf_n = 1'b1;
            if (wr) begin
               buf_n[wptr_q] = stream_d;
               wptr_n        = ~wptr_q;
            end
            if (hs)
               bcnt_n = pop ? '0 : bcnt_q + 1'b1;
            if (pop) begin
               rptr_n = ~rptr_q;
               vcnt_n = vcnt_q + 16'd1;
            end
            case ({wr, pop})
               2'b10:   occ_n = occ_q + 2'd1;
               2'b01:   occ_n = occ_q - 2'd1;
               default: occ_n = occ_q;
            endcase
            // Leftover buffered vectors are discarded at completion.
            if (finish || (len_q == 16'd0)) begin
               state_n = IDLE;
               done_n  = 1'b1;
               occ_n   = '0;
               wptr_n  = 1'b0;
               rptr_n  = 1'b0;
               bcnt_n  = '0;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n  = (state_n == RUN);
      valid_n = (state_n == RUN) && (occ_n != 2'd0);
      head_n  = buf_n[rptr_n];
      data_n  = valid_n ? head_n[int'(bcnt_n) * DW +: DW] : '0;
      last_n  = valid_n && (bcnt_n == BLAST) && (vcnt_n == len_n - 16'd1);
   end

   // State, buffer and registered outputs; reset aborts any job in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         occ_q    <= '0;
         bcnt_q   <= '0;
         vcnt_q   <= '0;
         len_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_n;
         buf_q    <= buf_n;
         wptr_q   <= wptr_n;
         rptr_q   <= rptr_n;
         occ_q    <= occ_n;
         bcnt_q   <= bcnt_n;
         vcnt_q   <= vcnt_n;
         len_q    <= len_n;
         data_q   <= data_n;
         valid_q  <= valid_n;
         last_q   <= last_n;
         busy     <= busy_n;
         done     <= done_n;
         overflow <= ovf_n;
      end
   end

endmodule

// File: tb/tb_hv_stream_packer.sv
// Directed bench for hv_stream_packer with a queue scoreboard: stimulus pushes
// expected beats, a negedge monitor pops and compares on every handshake.
module tb_hv_stream_packer;

   localparam int DIM = 1023;
   localparam int DW  = 64;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [15:0]      job_len = '0;
   logic             stream_v = 1'b0;
   logic [DIM:0]     stream_d = '0;
   logic             busy, done, overflow;

   hv_stream_packer_if #(.DW(DW)) dst_if ();

   hv_stream_packer #(.DIM(DIM), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .job_len  (job_len),
      .stream_v (stream_v),
      .stream_d (stream_d),
      .dst      (dst_if),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_beats = 0;
   bit          mon_en = 1'b0;
   beat_t       exp_q [$];
   logic        stall_prev = 1'b0;
   logic [63:0] prev_data = '0;
   logic        prev_last = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DIM:0] make_vec(input logic [7:0] seed);
      logic [DIM:0] v;
      for (int j = 0; j < (DIM + 1) / 8; j++) v[j*8 +: 8] = seed + 8'(j);
      return v;
   endfunction

   task automatic push_vec(input logic [DIM:0] v, input logic last_vec);
      beat_t b;
      for (int k = 0; k < (DIM + 1) / DW; k++) begin
         b.data = v[k*DW +: DW];
         b.last = last_vec && (k == (DIM + 1) / DW - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done within %0d cycles", bound);
      end
   endtask

   task automatic do_start(input logic [15:0] len);
      start   = 1'b1;
      job_len = len;
      tick();
      start   = 1'b0;
   endtask

   // Scoreboard monitor: compares each handshaked beat and stall stability.
   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (dst_if.dst_valid) begin
            if (stall_prev) begin
               check("stall_data", dst_if.dst_data, prev_data);
               check("stall_last", 64'(dst_if.dst_last), 64'(prev_last));
            end
            if (dst_if.dst_ready) begin
               n_beats++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat: got %h expected no beat", dst_if.dst_data);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  check("beat_data", dst_if.dst_data, e.data);
                  check("beat_last", 64'(dst_if.dst_last), 64'(e.last));
               end
            end
         end
         stall_prev = dst_if.dst_valid && !dst_if.dst_ready;
         prev_data  = dst_if.dst_data;
         prev_last  = dst_if.dst_last;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           n;
      int           vcount;
      logic [DIM:0] v1, v2, v3;
      int           pat [4] = '{1, 0, 0, 1};

      dst_if.dst_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", 64'(dst_if.dst_valid), 64'd0);
      check("rst_last", 64'(dst_if.dst_last), 64'd0);
      check("rst_data", dst_if.dst_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      rst = 1'b1;
      tick();
      mon_en = 1'b1;

      // Single vector, ready held high.
      do_start(16'd1);
      check("single_busy", 64'(busy), 64'd1);
      v1 = make_vec(8'h00);
      push_vec(v1, 1'b1);
      stream_v = 1'b1;
      stream_d = v1;
      tick();
      stream_v = 1'b0;
      check("single_lat_valid", 64'(dst_if.dst_valid), 64'd1);
      check("single_beat0", dst_if.dst_data, 64'h0706050403020100);
      wait_done(40, n);
      check("single_done_cycle", 64'(n), 64'd16);
      check("single_busy_at_done", 64'(busy), 64'd0);
      tick();
      check("single_done_pulse", 64'(done), 64'd0);
      check("single_q_empty", 64'(exp_q.size()), 64'd0);

      // Backpressure with ready pattern 1,0,0,1.
      n_beats = 0;
      do_start(16'd2);
      v1 = make_vec(8'h10);
      v2 = make_vec(8'h90);
      push_vec(v1, 1'b0);
      push_vec(v2, 1'b1);
      stream_v = 1'b1;
      stream_d = v1;
      tick();
      stream_d = v2;
      tick();
      stream_v = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         dst_if.dst_ready = pat[n % 4] != 0;
         tick();
         n++;
      end
      dst_if.dst_ready = 1'b1;
      check("bp_done_seen", 64'(done), 64'd1);
      check("bp_beats", 64'(n_beats), 64'd32);
      tick();

      // Overflow: ready low, three vectors, third dropped.
      dst_if.dst_ready = 1'b0;
      do_start(16'd4);
      v1 = make_vec(8'h21);
      v2 = make_vec(8'h55);
      push_vec(v1, 1'b0);
      push_vec(v2, 1'b0);
      stream_v = 1'b1;
      stream_d = v1;
      tick();
      stream_d = v2;
      tick();
      check("ovf_before_drop", 64'(overflow), 64'd0);
      stream_d = make_vec(8'hC3);
      tick();
      stream_v = 1'b0;
      check("ovf_set", 64'(overflow), 64'd1);
      check("ovf_head_valid", 64'(dst_if.dst_valid), 64'd1);
      check("ovf_head_beat0", dst_if.dst_data, v1[63:0]);
      dst_if.dst_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("ovf_drained", 64'(exp_q.size()), 64'd0);
      v1 = make_vec(8'h33);
      v2 = make_vec(8'h77);
      push_vec(v1, 1'b0);
      push_vec(v2, 1'b1);
      stream_v = 1'b1;
      stream_d = v1;
      tick();
      stream_d = v2;
      tick();
      stream_v = 1'b0;
      wait_done(100, n);
      check("ovf_sticky", 64'(overflow), 64'd1);
      tick();

      // Zero-length job; start also clears overflow.
      do_start(16'd0);
      check("zero_busy", 64'(busy), 64'd1);
      check("zero_ovf_clear", 64'(overflow), 64'd0);
      check("zero_valid", 64'(dst_if.dst_valid), 64'd0);
      tick();
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy_low", 64'(busy), 64'd0);
      check("zero_valid2", 64'(dst_if.dst_valid), 64'd0);
      tick();
      check("zero_done_pulse", 64'(done), 64'd0);

      // Write into a full buffer while the head's last beat handshakes.
      do_start(16'd3);
      v1 = make_vec(8'h01);
      v2 = make_vec(8'h81);
      v3 = make_vec(8'hE0);
      push_vec(v1, 1'b0);
      push_vec(v2, 1'b0);
      push_vec(v3, 1'b1);
      stream_v = 1'b1;
      stream_d = v1;
      tick();
      stream_d = v2;
      tick();
      stream_v = 1'b0;
      repeat (14) tick();
      stream_v = 1'b1;
      stream_d = v3;
      tick();
      stream_v = 1'b0;
      check("simul_ovf", 64'(overflow), 64'd0);
      check("simul_occ", 64'(dut.occ_q), 64'd2);
      wait_done(100, n);
      check("simul_done_cycle", 64'(n), 64'd32);
      tick();

      // Reset mid-job at beat 7 of the first vector.
      do_start(16'd2);
      v1 = make_vec(8'h40);
      v2 = make_vec(8'hA0);
      push_vec(v1, 1'b0);
      push_vec(v2, 1'b1);
      stream_v = 1'b1;
      stream_d = v1;
      tick();
      stream_d = v2;
      tick();
      stream_v = 1'b0;
      repeat (6) tick();
      check("rstmid_beat7", dst_if.dst_data, v1[7*64 +: 64]);
      mon_en = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("rstmid_valid", 64'(dst_if.dst_valid), 64'd0);
      check("rstmid_last", 64'(dst_if.dst_last), 64'd0);
      check("rstmid_data", dst_if.dst_data, 64'd0);
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_done", 64'(done), 64'd0);
      check("rstmid_ovf", 64'(overflow), 64'd0);
      exp_q.delete();
      tick();
      tick();
      rst = 1'b1;
      tick();
      mon_en = 1'b1;
      stream_v = 1'b1;
      stream_d = make_vec(8'h5A);
      tick();
      stream_v = 1'b0;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (dst_if.dst_valid) vcount++;
         tick();
      end
      check("rstmid_no_beats", 64'(vcount), 64'd0);
      check("rstmid_idle_busy", 64'(busy), 64'd0);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
